// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter over several FIFO outputs feeding a single registered
// valid/ready output channel; grants are one-hot and issued only when the output can load.
module rr_grant_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int WIDTH     = 64,
  parameter int PTR_W     = $clog2(NUM_PORTS)
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic [NUM_PORTS-1:0]       i_Valid,
  input  logic [NUM_PORTS*WIDTH-1:0] i_Data,
  output logic [NUM_PORTS-1:0]       o_Grant,
  output logic                       o_Valid,
  output logic [WIDTH-1:0]           o_Data,
  output logic [PTR_W-1:0]           o_Port,
  input  logic                       i_Ready
);

  localparam logic [PTR_W:0]   NP   = (PTR_W+1)'(NUM_PORTS);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_PORTS-1);

  logic [WIDTH-1:0] word [NUM_PORTS];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] port_q, port_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [PTR_W-1:0] pick;
  logic [PTR_W:0]   idx;
  logic             found;
  logic             load;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_word
    assign word[k] = i_Data[k*WIDTH +: WIDTH];
  end

  // Search from ptr upward; the one-bit-wider index wraps explicitly so
  // non-power-of-two port counts never address a nonexistent port.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (idx >= NP) idx = idx - NP;
      if (!found && i_Valid[idx[PTR_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[PTR_W-1:0];
      end
    end
  end

  assign load    = (|i_Valid) && (!valid_q || i_Ready) && !Reset;
  assign o_Grant = load ? (NUM_PORTS'(1) << pick) : '0;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    port_d  = port_q;
    ptr_d   = ptr_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = word[pick];
      port_d  = pick;
      ptr_d   = (pick == LAST) ? '0 : pick + PTR_W'(1);
    end else if (valid_q && i_Ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      port_q  <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      port_q  <= port_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_Valid = valid_q;
  assign o_Data  = data_q;
  assign o_Port  = port_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: a 4-port and a 3-port instance checked against
// a cycle-level reference model of the round-robin rules.
module tb_rr_grant_arbiter;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic [3:0]  v4 = '0;
  logic [2:0]  v3 = '0;
  logic        r4 = 1'b1, r3 = 1'b1;
  logic [15:0] d4 [4];
  logic [15:0] d3 [3];
  logic [63:0] bus4;
  logic [47:0] bus3;
  logic [3:0]  g4;
  logic [2:0]  g3;
  logic        ov4, ov3;
  logic [15:0] od4, od3;
  logic [1:0]  op4, op3;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state: index 0 = 4-port instance, 1 = 3-port instance
  int          m_ptr   [2];
  logic        m_valid [2];
  logic [15:0] m_data  [2];
  int          m_port  [2];

  always #5 CLK = ~CLK;

  for (genvar k = 0; k < 4; k++) begin : g_b4
    assign bus4[k*16 +: 16] = d4[k];
  end
  for (genvar k = 0; k < 3; k++) begin : g_b3
    assign bus3[k*16 +: 16] = d3[k];
  end

  rr_grant_arbiter #(.NUM_PORTS(4), .WIDTH(16)) dut4 (
    .CLK(CLK), .Reset(Reset), .i_Valid(v4), .i_Data(bus4), .o_Grant(g4),
    .o_Valid(ov4), .o_Data(od4), .o_Port(op4), .i_Ready(r4));

  rr_grant_arbiter #(.NUM_PORTS(3), .WIDTH(16)) dut3 (
    .CLK(CLK), .Reset(Reset), .i_Valid(v3), .i_Data(bus3), .o_Grant(g3),
    .o_Valid(ov3), .o_Data(od3), .o_Port(op3), .i_Ready(r3));

  function automatic int n_of(int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic int req_of(int d);
    return (d == 0) ? int'(v4) : int'(v3);
  endfunction

  // first requesting port scanning ptr, ptr+1, ... modulo N; -1 if none
  function automatic int m_pick(int d);
    int n = n_of(d);
    int vld = req_of(d);
    for (int i = 0; i < n; i++) begin
      int k = (m_ptr[d] + i) % n;
      if (((vld >> k) & 1) == 1) return k;
    end
    return -1;
  endfunction

  function automatic bit m_load(int d);
    bit rdy = (d == 0) ? r4 : r3;
    return (req_of(d) != 0) && (!m_valid[d] || rdy) && !Reset;
  endfunction

  function automatic logic [3:0] m_grant(int d);
    if (!m_load(d)) return 4'd0;
    return 4'(1 << m_pick(d));
  endfunction

  // advance model and DUTs by one clock edge; inputs are held across the edge
  task automatic tick();
    logic        nv [2];
    logic [15:0] nd [2];
    int          np [2];
    int          nptr [2];
    for (int d = 0; d < 2; d++) begin
      bit rdy = (d == 0) ? r4 : r3;
      nv[d] = m_valid[d]; nd[d] = m_data[d]; np[d] = m_port[d]; nptr[d] = m_ptr[d];
      if (Reset) begin
        nv[d] = 1'b0; nd[d] = '0; np[d] = 0; nptr[d] = 0;
      end else if (m_load(d)) begin
        int p = m_pick(d);
        nv[d] = 1'b1;
        nd[d] = (d == 0) ? d4[p] : d3[p];
        np[d] = p;
        nptr[d] = (p + 1) % n_of(d);
      end else if (m_valid[d] && rdy) begin
        nv[d] = 1'b0;
      end
    end
    @(posedge CLK);
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = nv[d]; m_data[d] = nd[d]; m_port[d] = np[d]; m_ptr[d] = nptr[d];
    end
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    v4 = 4'b1111; v3 = 3'b111; r4 = 1'b1; r3 = 1'b1;
    for (int k = 0; k < 4; k++) d4[k] = 16'h0A00 + 16'(k);
    for (int k = 0; k < 3; k++) d3[k] = 16'h0B00 + 16'(k);
    Reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      n_cmp++; if (g4 !== 4'b0000) begin n_bad++; $display("FAIL reset_grant4 c=%0d got %b want 0000", c, g4); end
      n_cmp++; if (g3 !== 3'b000) begin n_bad++; $display("FAIL reset_grant3 c=%0d got %b want 000", c, g3); end
      tick();
    end
    Reset = 1'b0; v4 = '0; v3 = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      n_cmp++;
      if (ov4 !== 1'b0 || od4 !== 16'h0 || op4 !== 2'd0 || g4 !== 4'b0000) begin
        n_bad++;
        $display("FAIL idle c=%0d got v=%b d=%h p=%0d g=%b want v=0 d=0000 p=0 g=0000", c, ov4, od4, op4, g4);
      end
      n_cmp++;
      if (ov3 !== 1'b0 || g3 !== 3'b000) begin n_bad++; $display("FAIL idle3 c=%0d got v=%b g=%b want 0/000", c, ov3, g3); end
      tick();
    end
  endtask

  task automatic test_full_contention();
    do_reset();
    for (int k = 0; k < 4; k++) d4[k] = 16'h0100 + 16'(k);
    v4 = 4'b1111; r4 = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge CLK);
      n_cmp++;
      if (g4 !== 4'(1 << (c % 4))) begin n_bad++; $display("FAIL contention_grant c=%0d got %b want %b", c, g4, 4'(1 << (c % 4))); end
      if (c > 0) begin
        n_cmp++;
        if (ov4 !== 1'b1 || od4 !== 16'h0100 + 16'((c - 1) % 4)) begin
          n_bad++; $display("FAIL contention_data c=%0d got v=%b d=%h want v=1 d=%h", c, ov4, od4, 16'h0100 + 16'((c - 1) % 4));
        end
      end
      tick();
    end
    v4 = '0;
    tick();
  endtask

  task automatic test_sparse_wrap();
    logic [3:0] exp_g [3];
    int         exp_p [3];
    exp_g[0] = 4'b0010; exp_g[1] = 4'b1000; exp_g[2] = 4'b0010;
    exp_p[0] = 1; exp_p[1] = 3; exp_p[2] = 1;
    do_reset();
    v4 = 4'b1010; r4 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      if (c < 3) begin
        n_cmp++; if (g4 !== exp_g[c]) begin n_bad++; $display("FAIL sparse_grant c=%0d got %b want %b", c, g4, exp_g[c]); end
      end
      if (c > 0) begin
        n_cmp++; if (int'(op4) != exp_p[c-1]) begin n_bad++; $display("FAIL sparse_port c=%0d got %0d want %0d", c, op4, exp_p[c-1]); end
      end
      tick();
    end
    v4 = '0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int k = 0; k < 4; k++) d4[k] = 16'h0200 + 16'(k);
    v4 = 4'b1111; r4 = 1'b1;
    @(negedge CLK);
    n_cmp++; if (g4 !== 4'b0001) begin n_bad++; $display("FAIL bp_first_grant got %b want 0001", g4); end
    tick();
    r4 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      n_cmp++;
      if (ov4 !== 1'b1 || od4 !== 16'h0200 || op4 !== 2'd0 || g4 !== 4'b0000) begin
        n_bad++; $display("FAIL bp_stall c=%0d got v=%b d=%h p=%0d g=%b want v=1 d=0200 p=0 g=0000", c, ov4, od4, op4, g4);
      end
      tick();
    end
    r4 = 1'b1;
    @(negedge CLK);
    n_cmp++; if (g4 !== 4'b0010) begin n_bad++; $display("FAIL bp_release_grant got %b want 0010", g4); end
    tick();
    @(negedge CLK);
    n_cmp++; if (op4 !== 2'd1 || od4 !== 16'h0201) begin n_bad++; $display("FAIL bp_release_out got p=%0d d=%h want p=1 d=0201", op4, od4); end
    v4 = '0;
    tick();
  endtask

  task automatic test_non_pow2();
    do_reset();
    for (int k = 0; k < 3; k++) d3[k] = 16'h0300 + 16'(k);
    v3 = 3'b111; r3 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      n_cmp++; if (g3 !== 3'(1 << (c % 3))) begin n_bad++; $display("FAIL np2_grant c=%0d got %b want %b", c, g3, 3'(1 << (c % 3))); end
      if (c > 0) begin
        n_cmp++;
        if (int'(op3) != (c - 1) % 3 || od3 !== 16'h0300 + 16'((c - 1) % 3)) begin
          n_bad++; $display("FAIL np2_out c=%0d got p=%0d d=%h want p=%0d", c, op3, od3, (c - 1) % 3);
        end
      end
      tick();
    end
    v3 = '0;
    tick();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    for (int k = 0; k < 4; k++) d4[k] = 16'h0400 + 16'(k);
    v4 = 4'b1111; r4 = 1'b1;
    tick();
    r4 = 1'b0;
    tick();
    Reset = 1'b1;
    @(negedge CLK);
    n_cmp++; if (g4 !== 4'b0000) begin n_bad++; $display("FAIL rst_stall_grant got %b want 0000", g4); end
    tick();
    Reset = 1'b0;
    @(negedge CLK);
    n_cmp++; if (ov4 !== 1'b0) begin n_bad++; $display("FAIL rst_stall_valid got %b want 0", ov4); end
    n_cmp++; if (g4 !== 4'b0001) begin n_bad++; $display("FAIL rst_stall_restart got %b want 0001", g4); end
    tick();
    v4 = '0; r4 = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      v4 = 4'($urandom); v3 = 3'($urandom);
      r4 = ($urandom_range(0, 3) != 0); r3 = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < 4; k++) d4[k] = 16'($urandom);
      for (int k = 0; k < 3; k++) d3[k] = 16'($urandom);
      Reset = ($urandom_range(0, 50) == 0);
      @(negedge CLK);
      n_cmp++;
      if (g4 !== m_grant(0) || ov4 !== m_valid[0] || (m_valid[0] && (od4 !== m_data[0] || int'(op4) != m_port[0]))) begin
        n_bad++; $display("FAIL rand4 c=%0d got g=%b v=%b d=%h p=%0d want g=%b v=%b d=%h p=%0d",
                          c, g4, ov4, od4, op4, m_grant(0), m_valid[0], m_data[0], m_port[0]);
      end
      n_cmp++;
      if ({1'b0, g3} !== m_grant(1) || ov3 !== m_valid[1] || (m_valid[1] && (od3 !== m_data[1] || int'(op3) != m_port[1]))) begin
        n_bad++; $display("FAIL rand3 c=%0d got g=%b v=%b d=%h p=%0d want g=%b v=%b d=%h p=%0d",
                          c, g3, ov3, od3, op3, m_grant(1), m_valid[1], m_data[1], m_port[1]);
      end
      tick();
    end
    Reset = 1'b0; v4 = '0; v3 = '0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = 0; m_valid[d] = 1'b0; m_data[d] = '0; m_port[d] = 0;
    end
    for (int k = 0; k < 4; k++) d4[k] = '0;
    for (int k = 0; k < 3; k++) d3[k] = '0;
    #1;
    test_reset();
    test_full_contention();
    test_sparse_wrap();
    test_backpressure();
    test_non_pow2();
    test_reset_mid_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_grant_arbiter.md
# rr_grant_arbiter

Round-robin arbiter and output register stage sitting directly downstream of several SyncFIFO_Bypass instances. It watches each FIFO's `o_Valid`/`o_Data` and drives each FIFO's `i_Grant` with a one-hot grant. It captures the granted word into a single registered output channel with a valid/ready handshake towards the next consumer. Arbitration is fair round-robin, so no requester can starve another.

## Interface
- `NUM_PORTS`, default 4: number of upstream FIFOs; legal range 2..16, need not be a power of two.
- `WIDTH`, default 64: data width per port.
- `PTR_W`, default `$clog2(NUM_PORTS)`: width of the port index; derived, never overridden.
- `CLK`  in  1  single clock.
- `Reset`  in  1  synchronous, active-high reset; sampled on the rising edge of `CLK`.
- `i_Valid`  in  NUM_PORTS  per-port data-available, from each FIFO's `o_Valid`.
- `i_Data`  in  NUM_PORTS*WIDTH  packed data; port k occupies bits [k*WIDTH +: WIDTH].
- `o_Grant`  out  NUM_PORTS  one-hot/zero grant, to each FIFO's `i_Grant`.
- `o_Valid`  out  1  output word valid.
- `o_Data`  out  WIDTH  output word.
- `o_Port`  out  PTR_W  index of the port that supplied `o_Data`.
- `i_Ready`  in  1  downstream accepts `o_Data` this cycle.

## Operation
- **State:**
  - priority pointer `ptr` (PTR_W bits);
  - output register `o_Valid`/`o_Data`/`o_Port`.
- **Load condition:** `load = (|i_Valid) && (!o_Valid || i_Ready) && !Reset`.
- **Pick:**
  - `pick` is the first k with `i_Valid[k]=1`, searching ptr, ptr+1, …, NUM_PORTS-1, 0, …, ptr-1.
  - The search wraps explicitly modulo NUM_PORTS, including non-power-of-two counts.
- **Grant:**
  - `o_Grant = load ? (1 << pick) : 0`.
  - The grant is combinational from `i_Valid`, `i_Ready`, `o_Valid` and `ptr`.
  - At most one bit is ever set.
  - A grant is never issued to a port whose `i_Valid` is 0.
- **On load (registered at the rising edge):**
  - `o_Data <= i_Data[pick]`, `o_Port <= pick`, `o_Valid <= 1`;
  - `ptr <= (pick == NUM_PORTS-1) ? 0 : pick+1`.
- **No load, `o_Valid && i_Ready`:** `o_Valid <= 0`. `o_Data`/`o_Port` hold their last value.
- **No load, `o_Valid && !i_Ready`:** all output registers hold (stall). `ptr` holds.
- **No valid input, `o_Valid=0`:** idle. `ptr` holds.
- **Reset:**
  - `o_Valid=0`, `o_Data=0`, `o_Port=0`, `ptr=0`.
  - `o_Grant` is forced to 0 during every cycle `Reset` is high.
  - Reset mid-stall discards the held word. The upstream FIFO is not re-granted for it; that word is lost by design.
- **Upstream contract:** `i_Data[k]` in the cycle where `o_Grant[k]=1` is the word consumed. FIFO k advances its output on the next edge.

## Timing
- Grant-to-output latency is 1 cycle: grant in cycle t → `o_Valid`/`o_Data` valid from cycle t+1.
- Throughput is 1 word/cycle with `i_Ready` held high. Back-to-back grants are allowed every cycle.
- **Transfer and refill:** a word is transferred in every cycle where `o_Valid && i_Ready`. In that same cycle a new grant may issue, so the output refills with no bubble.
- **Stall:** while `o_Valid && !i_Ready`, `o_Grant` stays 0 and `o_Valid`/`o_Data`/`o_Port` are stable.
- **Fairness:** with all NUM_PORTS requesting continuously, each port is granted exactly once in every NUM_PORTS consecutive grants.
- **Simultaneous events:**
  - A new request arriving at the port equal to `ptr` in the same cycle as other requests wins.
  - Requests that drop before being granted are simply skipped; nothing is latched.

## Test plan
- **Reset, then idle:** after `Reset`, `i_Valid=0000`, `i_Ready=1` → `o_Valid=0`, `o_Data=0`, `o_Port=0`, `o_Grant=0000` for 10 cycles.
- **Full contention:**
  - Stimulus: NUM_PORTS=4, `i_Valid=1111` constant, `i_Ready=1`, `i_Data[k]=0x100+k`.
  - Grants: `o_Grant` sequence is 0001, 0010, 0100, 1000, 0001…
  - Output: `o_Data` one cycle later is 0x100, 0x101, 0x102, 0x103, 0x100.
- **Sparse requests with wrap:**
  - Stimulus: `ptr=0`, `i_Valid=1010`.
  - Required: grants are 0010, then 1000, then 0010; `o_Port` is 1, 3, 1.
- **Backpressure:**
  - Stimulus: `i_Valid=1111`, `i_Ready=0` for 5 cycles after the first load.
  - Stall: `o_Valid=1`, `o_Data` is held at the port-0 word, and `o_Grant=0000` throughout.
  - Release: on `i_Ready=1`, the same cycle grants port 1, and `o_Port=1` appears on the next cycle.
- **Non-power-of-two:** NUM_PORTS=3, all requesting → grant order 001, 010, 100, 001; `ptr` never reaches 3.
- **Synchronous reset mid-stall:**
  - Stimulus: `o_Valid=1`, `i_Ready=0`, assert `Reset` for 1 cycle.
  - Required: `o_Valid=0` and `o_Grant=0` after the edge; arbitration restarts from port 0.
